// File: rtl/core_sequencer_if.sv
// Handshake bundle between the core sequencer and
// the fetch port, the execution unit and data memory.
interface core_sequencer_if #(
  parameter int XLEN = 64
);
  logic            ifu_req;
  logic            ifu_ack;
  logic [31:0]     ifu_inst;
  logic            exu_start;
  logic            exu_done;
  logic [XLEN-1:0] next_pc;
  logic            mem_req;
  logic            mem_wen;
  logic            mem_ack;

  modport master (
    output ifu_req, exu_start, mem_req, mem_wen,
    input  ifu_ack, ifu_inst, exu_done, next_pc, mem_ack
  );

  modport slave (
    input  ifu_req, exu_start, mem_req, mem_wen,
    output ifu_ack, ifu_inst, exu_done, next_pc, mem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM of the RV64 core: owns pc and
// the latched instruction, sequences fetch..writeback.
module core_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.master bus,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  pc,
  output logic             rf_we,
  output logic             retire,
  output logic [XLEN-1:0]  minstret,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_MISC   = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_32     = 7'h3B;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc_q;
  logic [XLEN-1:0] minstret_q;
  logic [31:0]     inst_q;
  logic            halted_q;
  logic            illegal_q;
  logic            ifu_req_q;
  logic            exu_start_q;
  logic            mem_req_q;
  logic            mem_wen_q;
  logic            rf_we_q;
  logic            retire_q;

  logic [6:0] opc;
  logic       legal_d;
  logic       wr_rd_d;
  logic       is_mem_d;
  logic       is_store_d;

  assign opc        = inst_q[6:0];
  assign is_store_d = (opc == OP_STORE);
  assign is_mem_d   = (opc == OP_LOAD) || is_store_d;

  // Classify the latched opcode: legality and rd writeback.
  always_comb begin
    legal_d = 1'b1;
    wr_rd_d = 1'b0;
    unique case (opc)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_IMM_32, OP_OP,
      OP_LUI, OP_32, OP_JALR, OP_JAL:
        wr_rd_d = 1'b1;
      OP_STORE, OP_BRANCH, OP_MISC:
        wr_rd_d = 1'b0;
      OP_SYSTEM:
        wr_rd_d = (inst_q[14:12] != 3'd0);
      default:
        legal_d = 1'b0;
    endcase
    if (inst_q[11:7] == 5'd0) begin
      wr_rd_d = 1'b0;
    end
  end

  // Sequencer FSM; outputs are set on entry to each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RST;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC;
      minstret_q  <= '0;
      inst_q      <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      ifu_req_q   <= 1'b0;
      exu_start_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      retire_q    <= 1'b0;
    end else begin
      exu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      retire_q    <= 1'b0;
      unique case (state_q)
        S_RST: begin
          state_q   <= S_FETCH;
          ifu_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.ifu_ack) begin
            inst_q    <= bus.ifu_inst;
            ifu_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (inst_q == EBREAK) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b0;
          end else if (!legal_d) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            state_q     <= S_EXEC;
            exu_start_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (bus.exu_done) begin
            npc_q <= bus.next_pc;
            if (is_mem_d) begin
              state_q   <= S_MEM;
              mem_req_q <= 1'b1;
              mem_wen_q <= is_store_d;
            end else begin
              state_q  <= S_WB;
              retire_q <= 1'b1;
              rf_we_q  <= wr_rd_d;
            end
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_wen_q <= 1'b0;
            state_q   <= S_WB;
            retire_q  <= 1'b1;
            rf_we_q   <= wr_rd_d;
          end
        end
        S_WB: begin
          pc_q       <= npc_q;
          minstret_q <= minstret_q + XLEN'(1);
          state_q    <= S_FETCH;
          ifu_req_q  <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RST;
        end
      endcase
    end
  end

  assign bus.ifu_req   = ifu_req_q;
  assign bus.exu_start = exu_start_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = mem_wen_q;
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign rf_we         = rf_we_q;
  assign retire        = retire_q;
  assign minstret      = minstret_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Random and directed bench for core_sequencer with a
// per-instruction reference model.
module tb_core_sequencer;
  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int K_EBRK = 0;
  localparam int K_ILL  = 1;
  localparam int K_LD   = 2;
  localparam int K_ST   = 3;
  localparam int K_ALU  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] minstret;
  logic            rf_we;
  logic            retire;
  logic            halted;
  logic            illegal;
  logic [2:0]      state;

  int errs   = 0;
  int checks = 0;

  logic [63:0] m_pc;
  logic [63:0] m_ret;
  logic [6:0]  OPS [13] = '{7'h03, 7'h0F, 7'h13, 7'h17,
    7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67,
    7'h6F, 7'h73};

  always #5 clk = ~clk;

  core_sequencer_if #(.XLEN(XLEN)) bus ();

  core_sequencer #(
    .XLEN(XLEN),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .inst(inst),
    .pc(pc),
    .rf_we(rf_we),
    .retire(retire),
    .minstret(minstret),
    .halted(halted),
    .illegal(illegal),
    .state(state)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int kind(input logic [31:0] i);
    if (i == 32'h0010_0073) return K_EBRK;
    case (i[6:0])
      7'h03: return K_LD;
      7'h23: return K_ST;
      7'h0F, 7'h13, 7'h17, 7'h1B, 7'h33, 7'h37,
      7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73:
        return K_ALU;
      default: return K_ILL;
    endcase
  endfunction

  function automatic bit writes_rd(input logic [31:0] i);
    int k;
    k = kind(i);
    if (k != K_LD && k != K_ALU) return 1'b0;
    if (i[11:7] == 5'd0) return 1'b0;
    if (i[6:0] inside {7'h23, 7'h63, 7'h0F}) return 1'b0;
    if (i[6:0] == 7'h73 && i[14:12] == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle_inputs();
    bus.ifu_ack  = 1'b0;
    bus.ifu_inst = $urandom;
    bus.exu_done = 1'b0;
    bus.next_pc  = {$urandom, $urandom};
    bus.mem_ack  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_minstret", minstret, 0);
    chk("rst_inst", inst, 0);
    chk("rst_flags", {halted, illegal}, 2'b00);
    chk("rst_outs", {bus.ifu_req, bus.exu_start,
        bus.mem_req, rf_we, retire}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rel_state", state, 3'd0);
    @(negedge clk);
    chk("fetch_state", state, 3'd1);
    chk("fetch_req", bus.ifu_req, 1'b1);
    m_pc  = RESET_PC;
    m_ret = 0;
  endtask

  // Caller is at a negedge with the DUT in FETCH.
  task automatic run(input logic [31:0] ins,
                     input logic [63:0] npc,
                     input int fw, input int ew,
                     input int mw, input bit abort_mem);
    int cyc = 0, reqc = 0, exc = 0, memc = 0;
    int startc = 0, retc = 0, wec = 0, wenc = 0;
    bit done = 1'b0, stable = 1'b1;
    logic [31:0] prev = inst;
    int k = kind(ins);
    while (!done && cyc < 200) begin
      cyc++;
      if (halted || (cyc > 1 && bus.ifu_req && retc > 0)) begin
        done = 1'b1;
        break;
      end
      idle_inputs();
      if (bus.ifu_req) begin
        reqc++;
        if (inst !== prev) stable = 1'b0;
        if (reqc == fw + 1) begin
          bus.ifu_ack  = 1'b1;
          bus.ifu_inst = ins;
        end
      end else begin
        bus.ifu_ack = 1'($urandom_range(0, 1));
      end
      if (bus.exu_start) startc++;
      if (state == 3'd3) begin
        exc++;
        if (exc == ew + 1) begin
          bus.exu_done = 1'b1;
          bus.next_pc  = npc;
        end
      end
      if (bus.mem_req) begin
        memc++;
        if (bus.mem_wen) wenc++;
        if (abort_mem && memc == 2) return;
        if (memc == mw + 1) bus.mem_ack = 1'b1;
      end
      if (retire) retc++;
      if (rf_we) wec++;
      @(negedge clk);
    end
    chk("done_in_budget", done, 1'b1);
    if (k == K_EBRK || k == K_ILL) begin
      chk("halt_lat", cyc, 3 + fw);
      chk("halt_flags", {halted, illegal},
          {1'b1, k == K_ILL});
      chk("halt_pc", pc, m_pc);
      chk("halt_minstret", minstret, m_ret);
      chk("halt_noexec", startc + retc, 0);
      repeat (3) begin
        idle_inputs();
        bus.ifu_ack = 1'b1;
        @(negedge clk);
        chk("halt_quiet", {bus.ifu_req, bus.exu_start,
            bus.mem_req, retire, rf_we, halted}, 6'b000001);
        chk("halt_state", state, 3'd6);
      end
    end else begin
      m_pc  = npc;
      m_ret = m_ret + 1;
      chk("lat", cyc, 5 + fw + ew +
          ((k == K_LD || k == K_ST) ? 1 + mw : 0));
      chk("inst", inst, ins);
      chk("inst_stable", stable, 1'b1);
      chk("req_cycles", reqc, fw + 1);
      chk("exu_start_cnt", startc, 1);
      chk("retire_cnt", retc, 1);
      chk("rf_we_cnt", wec, writes_rd(ins) ? 1 : 0);
      chk("mem_cycles", memc,
          (k == K_LD || k == K_ST) ? mw + 1 : 0);
      chk("mem_wen_cycles", wenc, (k == K_ST) ? mw + 1 : 0);
      chk("pc", pc, m_pc);
      chk("minstret", minstret, m_ret);
    end
  endtask

  initial begin
    logic [31:0] ri;
    logic [63:0] rn;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    do_reset();

    run(32'h0050_0093, 64'h8000_0004, 0, 0, 0, 1'b0);
    run(32'h00a0_0113, 64'h8000_0008, 4, 0, 0, 1'b0);
    run(32'h0011_2023, 64'h8000_000c, 0, 0, 3, 1'b0);
    run(32'h0001_2283, 64'h8000_0010, 0, 1, 0, 1'b0);
    run(32'h0000_0013, 64'h8000_0014, 0, 0, 0, 1'b0);
    run(32'h0000_0063, 64'h8000_0100, 0, 0, 0, 1'b0);
    run(32'h0000_0073, 64'h8000_0104, 1, 0, 0, 1'b0);
    run(32'h3000_2573, 64'h8000_0108, 0, 2, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ri = $urandom;
      ri[6:0] = OPS[$urandom_range(0, 12)];
      if (kind(ri) == K_EBRK) ri[7] = 1'b1;
      rn = ($urandom_range(0, 1) != 0) ? m_pc + 4 :
           {$urandom, $urandom[31:2], 2'b00};
      run(ri, rn, $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    run(32'h0001_2283, 64'h8000_0200, 0, 0, 5, 1'b1);
    chk("abort_in_mem", {bus.mem_req, state}, {1'b1, 3'd4});
    do_reset();

    run(32'h0050_0093, 64'h8000_0004, 0, 0, 0, 1'b0);
    run(32'h0010_0073, 64'h0, 2, 0, 0, 1'b0);
    do_reset();
    run(32'h0000_007F, 64'h0, 0, 0, 0, 1'b0);
    do_reset();
    run(32'h0050_0093, 64'h8000_0004, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RV64 core.
- Owns the PC and the latched instruction word.
- Sequences fetch, decode, execute, memory and writeback by handshaking with the instruction fetch port, the EXU and the data memory port.
- Drives register-file and PC write enables, stops the core on ebreak or an illegal opcode, and counts retired instructions.

Parameters:
- XLEN, 64, datapath width; pc, next_pc and minstret are XLEN bits.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ifu_req  out  1  instruction fetch request at address pc
- ifu_ack  in  1  fetch complete; ifu_inst valid this cycle
- ifu_inst  in  32  fetched instruction
- inst  out  32  latched instruction word, feeds the decoder
- pc  out  XLEN  current PC
- exu_start  out  1  one-cycle pulse starting execution
- exu_done  in  1  EXU result (and next_pc / mem address) valid
- next_pc  in  XLEN  PC computed by the EXU
- mem_req  out  1  data memory request
- mem_wen  out  1  1 = store, 0 = load; valid while mem_req=1
- mem_ack  in  1  data memory access complete
- rf_we  out  1  register-file write enable, one cycle
- retire  out  1  one-cycle pulse when an instruction commits
- minstret  out  XLEN  retired-instruction counter
- halted  out  1  core stopped
- illegal  out  1  stop cause is an illegal opcode (valid when halted=1)
- state  out  3  current FSM state, debug

Behaviour:
- Encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Clock and reset:
  - All registers update on posedge clk.
  - rst=1 forces state=RST, pc=RESET_PC, inst=0, minstret=0, halted=0, illegal=0.
  - All request and enable outputs are 0 during reset.
  - rst overrides every other input in any state, including mid-handshake.
- RST: one cycle after rst deasserts, then FETCH.
- FETCH:
  - ifu_req=1 continuously until ifu_ack.
  - On ifu_ack: inst<=ifu_inst, go DECODE.
  - ifu_ack seen while not in FETCH is ignored.
- DECODE: exactly one cycle, classifying inst[6:0].
  - inst==32'h0010_0073 (ebreak): go HALT, illegal=0.
  - Opcode not in {LOAD, MISC_MEM, OP_IMM, AUIPC, OP_IMM_32, STORE, OP, LUI, OP_32, BRANCH, JALR, JAL, SYSTEM}: go HALT, illegal=1.
  - Otherwise go EXEC.
- EXEC:
  - exu_start=1 on the first EXEC cycle only.
  - Wait for exu_done; exu_done may arrive in that same first cycle.
  - On exu_done: LOAD/STORE go to MEM; all other opcodes go to WB.
  - next_pc is captured on exu_done into a next-PC register.
- MEM:
  - mem_req=1 held until mem_ack.
  - mem_wen=1 for STORE, 0 for LOAD.
  - On mem_ack: go WB.
- WB: one cycle.
  - pc<=captured next_pc.
  - retire=1; minstret<=minstret+1, wrapping modulo 2^XLEN.
  - rf_we=1 iff inst[11:7]!=0 and the opcode writes rd: all legal opcodes except STORE, BRANCH, MISC_MEM; SYSTEM only when funct3!=0.
  - Then go FETCH.
- HALT:
  - Absorbing until rst; halted=1.
  - All requests, rf_we and retire are 0.
  - pc and minstret hold; ebreak is not counted as retired.
- Outputs:
  - All outputs are registered state or pure decodes of the current state and inst.
  - No output depends combinationally on ifu_ack, exu_done or mem_ack.
- Latency: minimum 5 cycles per non-memory instruction (FETCH, DECODE, EXEC, WB with zero-wait acks, plus one), 6 for loads/stores.

Test Plan:
- Reset: hold rst 3 cycles, release → state RST then FETCH; pc=0x80000000, ifu_req=1 one cycle after release.
- addi: ifu_inst=0x00500093 (addi x1,x0,5), ack immediately; exu_done same cycle as exu_start, next_pc=0x80000004 → WB has rf_we=1, retire=1; pc=0x80000004 and minstret=1 after WB; total 5 cycles.
- Fetch stall: ifu_ack delayed 4 cycles → ifu_req stays 1 for 5 cycles and inst does not change until ack.
- Store, then load:
  - sw (0x00112023) with mem_ack after 3 cycles → mem_req=1 and mem_wen=1 for 4 cycles, rf_we=0 in WB.
  - lw x5 (0x00012283) → mem_wen=0, rf_we=1.
- Write to x0 and branch:
  - addi x0 (0x00000013) → rf_we=0, retire=1.
  - beq with next_pc=0x80000100 → pc=0x80000100, rf_we=0.
- Halts and reset recovery:
  - ebreak (0x00100073) → HALT, halted=1, illegal=0, minstret unchanged.
  - Opcode 0x7F → halted=1, illegal=1.
  - Then assert rst during HALT → state=RST, pc=0x80000000, halted=0.
  - Assert rst while in MEM with mem_req high → mem_req=0 the next cycle.
